iterative_muldiv_unit: RTL and testbench

- Multi-cycle unsigned multiply/divide execution unit in the LEGv8 datapath.
- Sits between the register file read ports (BusA, BusB) and its write port (BusW, RW, RegWr).
- Latches operands on a start pulse and iterates one bit per cycle (shift-add for multiply, restoring shift-subtract for divide).
- Delivers a one-cycle write-back request that the register file captures on the falling clock edge.

---
 rtl/iterative_muldiv_unit_pkg.sv | 27 ++
 rtl/iterative_muldiv_unit_if.sv | 25 ++
 rtl/iterative_muldiv_unit_datapath.sv | 59 +++++
 rtl/iterative_muldiv_unit.sv | 101 ++++++++++
 tb/tb_iterative_muldiv_unit.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/iterative_muldiv_unit_pkg.sv
// Shared opcode and state encodings for the iterative multiply/divide unit.
// The instruction decoder that drives Op uses the same constants.
package iterative_muldiv_unit_pkg;

  typedef enum logic [1:0] {
    OP_MUL   = 2'b00,
    OP_UMULH = 2'b01,
    OP_UDIV  = 2'b10,
    OP_UREM  = 2'b11
  } opCode_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic logic isDivide(input opCode_t op);
    return op[1];
  endfunction

  // MUL and UDIV take the low half of the working register, UMULH and UREM the high half.
  function automatic logic selectsHigh(input opCode_t op);
    return op[0];
  endfunction

endpackage

// File: rtl/iterative_muldiv_unit_if.sv
// Request/write-back bundle between the register file ports and the muldiv unit.
interface iterative_muldiv_unit_if #(
  parameter int WIDTH = 64
);
  logic             Start;
  logic [1:0]       Op;
  logic [WIDTH-1:0] OpA;
  logic [WIDTH-1:0] OpB;
  logic [4:0]       RdIn;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Result;
  logic [4:0]       RWOut;
  logic             RegWrOut;

  modport master (
    output Start, Op, OpA, OpB, RdIn,
    input  Busy, Done, Result, RWOut, RegWrOut
  );

  modport slave (
    input  Start, Op, OpA, OpB, RdIn,
    output Busy, Done, Result, RWOut, RegWrOut
  );
endinterface

// File: rtl/iterative_muldiv_unit_datapath.sv
// Shared 2*WIDTH working register with the shift-add / restoring shift-subtract step.
// Multiply holds {product high, multiplier/product low}; divide holds {remainder, quotient}.
module muldiv_datapath #(
  parameter int WIDTH = 64
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             load,
  input  logic             step,
  input  logic             loadDiv,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  output logic [WIDTH-1:0] nextLo,
  output logic [WIDTH-1:0] nextHi
);

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] accStep;
  logic [WIDTH-1:0]   operand;
  logic               divMode;
  logic [WIDTH:0]     mulSum;
  logic [WIDTH:0]     divTrial;
  logic [WIDTH-1:0]   divDiff;

  always_comb begin
    accStep  = acc;
    mulSum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
    // The bit shifted out of the remainder must take part in the compare.
    divTrial = acc[2*WIDTH-1:WIDTH-1];
    divDiff  = divTrial[WIDTH-1:0] - operand;
    if (divMode) begin
      if (divTrial >= {1'b0, operand}) begin
        accStep = {divDiff, acc[WIDTH-2:0], 1'b1};
      end else begin
        accStep = {divTrial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end
    end else begin
      accStep = {mulSum, acc[WIDTH-1:1]};
    end
  end

  assign nextLo = accStep[WIDTH-1:0];
  assign nextHi = accStep[2*WIDTH-1:WIDTH];

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      acc     <= '0;
      operand <= '0;
      divMode <= 1'b0;
    end else if (load) begin
      acc     <= {{WIDTH{1'b0}}, (loadDiv ? opA : opB)};
      operand <= loadDiv ? opB : opA;
      divMode <= loadDiv;
    end else if (step) begin
      acc <= accStep;
    end
  end

endmodule

// File: rtl/iterative_muldiv_unit.sv
// Multi-cycle unsigned MUL/UMULH/UDIV/UREM unit: one bit per cycle, then a
// one-cycle write-back request to the register file.
module iterative_muldiv_unit
  import iterative_muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int CNTW  = 7
) (
  input logic               Clk,
  input logic               Reset,
  iterative_muldiv_unit_if.slave bus
);

  state_t           state;
  state_t           stateNext;
  opCode_t          opReg;
  logic [4:0]       rdReg;
  logic [CNTW-1:0]  count;
  logic [WIDTH-1:0] resultReg;
  logic [4:0]       rwReg;
  logic             load;
  logic             step;
  logic             lastIter;
  logic             divByZero;
  logic [WIDTH-1:0] nextLo;
  logic [WIDTH-1:0] nextHi;

  assign divByZero = isDivide(opCode_t'(bus.Op)) && (bus.OpB == '0);
  assign lastIter  = (count == CNTW'(WIDTH - 1));

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= S_IDLE;
    else       state <= stateNext;
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    stateNext = state;
    load      = 1'b0;
    step      = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (bus.Start) begin
          load      = 1'b1;
          stateNext = divByZero ? S_DONE : S_BUSY;
        end
      end
      S_BUSY: begin
        step = 1'b1;
        if (lastIter) stateNext = S_DONE;
      end
      S_DONE:  stateNext = S_IDLE;
      default: stateNext = S_IDLE;
    endcase
  end

  // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      count     <= '0;
      opReg     <= OP_MUL;
      rdReg     <= '0;
      resultReg <= '0;
      rwReg     <= '0;
    end else if (load) begin
      count <= '0;
      opReg <= opCode_t'(bus.Op);
      rdReg <= bus.RdIn;
      if (divByZero) begin
        resultReg <= (opCode_t'(bus.Op) == OP_UREM) ? bus.OpA : '0;
        rwReg     <= bus.RdIn;
      end
    end else if (step) begin
      count <= count + 1'b1;
      // The final iteration's result is taken from the step logic, not the stale register.
      if (lastIter) begin
        resultReg <= selectsHigh(opReg) ? nextHi : nextLo;
        rwReg     <= rdReg;
      end
    end
  end

  muldiv_datapath #(.WIDTH(WIDTH)) uDatapath (
    .Clk     (Clk),
    .Reset   (Reset),
    .load    (load),
    .step    (step),
    .loadDiv (isDivide(opCode_t'(bus.Op))),
    .opA     (bus.OpA),
    .opB     (bus.OpB),
    .nextLo  (nextLo),
    .nextHi  (nextHi)
  );

  assign bus.Busy     = (state != S_IDLE);
  assign bus.Done     = (state == S_DONE);
  assign bus.RegWrOut = (state == S_DONE);
  assign bus.Result   = resultReg;
  assign bus.RWOut    = rwReg;

endmodule

// File: tb/tb_iterative_muldiv_unit.sv
// Directed and randomized bench for iterative_muldiv_unit against an arithmetic
// reference model and a negedge-write register file model.
module tb_iterative_muldiv_unit;
  import iterative_muldiv_unit_pkg::*;

  localparam int W = 64;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   startCyc = 0;
  logic [W-1:0] expResult;
  int           expLat;
  logic [4:0]   expRd;
  logic [W-1:0] regFile [32];

  iterative_muldiv_unit_if #(.WIDTH(W)) bus ();

  iterative_muldiv_unit #(.WIDTH(W), .CNTW(7)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  always @(negedge Clk) begin
    if (bus.RegWrOut && bus.RWOut != 5'd31) regFile[bus.RWOut] <= bus.Result;
  end

  function automatic logic [W-1:0] rfRead(input logic [4:0] idx);
    return (idx == 5'd31) ? '0 : regFile[idx];
  endfunction

  function automatic logic [W-1:0] refModel(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] prod;
    prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    case (op)
      OP_MUL:   return prod[W-1:0];
      OP_UMULH: return prod[2*W-1:W];
      OP_UDIV:  return (b == 0) ? '0 : a / b;
      default:  return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic check(input string tag, input logic [W-1:0] observed, input logic [W-1:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Called at a negedge; returns at the negedge after the start posedge.
  task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input logic [4:0] rd);
    bus.Start = 1'b1;
    bus.Op    = op;
    bus.OpA   = a;
    bus.OpB   = b;
    bus.RdIn  = rd;
    expResult = refModel(op, a, b);
    expLat    = (op[1] && b == 0) ? 1 : W + 1;
    expRd     = rd;
    @(negedge Clk);
    startCyc  = cyc;
    bus.Start = 1'b0;
    bus.OpA   = {$urandom, $urandom};
    bus.OpB   = {$urandom, $urandom};
    bus.RdIn  = 5'($urandom);
  endtask

  task automatic finish(input string tag);
    int guard = 0;
    while (!bus.Done && guard < 300) begin
      @(negedge Clk);
      guard++;
    end
    if (!bus.Done) begin
      check({tag, " timeout"}, 0, 1);
    end else begin
      check({tag, " latency"}, W'(cyc - startCyc + 1), W'(expLat));
      check({tag, " result"}, bus.Result, expResult);
      check({tag, " rw"}, W'(bus.RWOut), W'(expRd));
      check({tag, " regwr"}, W'(bus.RegWrOut), 1);
      @(negedge Clk);
      check({tag, " done one cycle"}, W'({bus.Done, bus.RegWrOut}), 0);
      check({tag, " result hold"}, bus.Result, expResult);
    end
  endtask

  initial begin
    logic [1:0]   op;
    logic [W-1:0] a, b;
    for (int i = 0; i < 32; i++) regFile[i] = '0;
    bus.Start = 1'b0;
    bus.Op    = OP_MUL;
    bus.OpA   = '0;
    bus.OpB   = '0;
    bus.RdIn  = '0;

    @(negedge Clk);
    check("reset busy", W'(bus.Busy), 0);
    check("reset done", W'(bus.Done), 0);
    check("reset regwr", W'(bus.RegWrOut), 0);
    check("reset result", bus.Result, 0);
    check("reset rw", W'(bus.RWOut), 0);
    Reset = 1'b0;

    issue(OP_MUL, {W{1'b1}}, {W{1'b1}}, 5'd5);
    finish("mul max");
    issue(OP_UMULH, {W{1'b1}}, {W{1'b1}}, 5'd5);
    finish("umulh max");

    issue(OP_MUL, 7, 9, 5'd3);
    repeat (20) @(negedge Clk);
    #2 Reset = 1'b1;
    #1;
    check("async reset busy", W'(bus.Busy), 0);
    check("async reset done", W'(bus.Done), 0);
    check("async reset result", bus.Result, 0);
    @(negedge Clk);
    Reset = 1'b0;
    issue(OP_MUL, 7, 9, 5'd3);
    finish("mul after reset");

    issue(OP_UDIV, 100, 7, 5'd1);
    finish("udiv 100/7");
    issue(OP_UREM, 100, 7, 5'd2);
    finish("urem 100/7");
    issue(OP_UDIV, 5, 9, 5'd1);
    finish("udiv 5/9");
    issue(OP_UREM, 5, 9, 5'd2);
    finish("urem 5/9");
    issue(OP_UDIV, 1234, 0, 5'd4);
    finish("udiv by zero");
    issue(OP_UREM, 1234, 0, 5'd4);
    finish("urem by zero");

    issue(OP_MUL, 2, 2, 5'd6);
    repeat (10) @(negedge Clk);
    bus.Start = 1'b1;
    bus.Op    = OP_MUL;
    bus.OpA   = 3;
    bus.OpB   = 3;
    bus.RdIn  = 5'd7;
    @(negedge Clk);
    bus.Start = 1'b0;
    finish("start while busy");
    issue(OP_MUL, 11, 13, 5'd8);
    finish("back to back");

    issue(OP_MUL, 6, 7, 5'd31);
    finish("xzr write");
    check("xzr readback", rfRead(5'd31), 0);
    issue(OP_MUL, 6, 7, 5'd12);
    finish("x12 write");
    check("x12 readback", rfRead(5'd12), 42);

    for (int i = 0; i < 10; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = ($urandom_range(0, 1) == 0) ? W'($urandom_range(0, 1000)) : {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0:       b = '0;
        1:       b = W'($urandom_range(1, 255));
        default: b = {$urandom, $urandom};
      endcase
      issue(op, a, b, 5'($urandom_range(0, 30)));
      finish($sformatf("random %0d op%0d", i, op));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
